// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall-vector encodings,
// the ERET exception code, stop flags, FSM states and a stall priority encoder.
package pipe_ctrl_pkg;

  // Stall vectors, bit order {wb, mem, ex, id, if, pc}; 1 = hold stage.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf   = 6'b000011;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  localparam logic [4:0]  ExcEret  = 5'h0E;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun,
    StRecover
  } ctrl_state_e;

  // The deepest requesting stage wins: it and everything upstream of it hold.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] vec;
    if (req_mem == Stop) begin
      vec = StallMem;
    end else if (req_ex == Stop) begin
      vec = StallEx;
    end else if (req_id == Stop) begin
      vec = StallId;
    end else if (req_if == Stop) begin
      vec = StallIf;
    end else begin
      vec = StallNone;
    end
    return vec;
  endfunction

endpackage

// File: rtl/ctrl_wdog.sv
// Stall watchdog and stall-cycle performance counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stall_pc      stall[0] of the controller (pc held this cycle)
//   flush         pipeline flush this cycle; restarts the watchdog
//   wdog_timeout  one-cycle pulse on the WDOG_LIMIT-th consecutive stall cycle
//   stall_err     sticky timeout flag, cleared only by rst
//   stall_cycles  saturating count of cycles with stall_pc set
module ctrl_wdog #(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  output logic        wdog_timeout,
  output logic        stall_err,
  output logic [31:0] stall_cycles
);

  localparam int unsigned     CntW    = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WDOG_LIMIT - 1);

  logic [CntW-1:0] wdog_cnt_q;
  logic            stalled;
  logic            hit;

  always_comb begin
    stalled      = stall_pc && !flush;
    // The counter holds the number of earlier stall cycles, so the limit is
    // reached when this cycle stalls with LIMIT-1 already counted.
    hit          = !rst && stalled && (wdog_cnt_q == LastCnt);
    wdog_timeout = hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q   <= '0;
      stall_err    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (!stalled || hit) begin
        wdog_cnt_q <= '0;
      end else begin
        wdog_cnt_q <= wdog_cnt_q + CntW'(1);
      end
      if (hit) begin
        stall_err <= 1'b1;
      end
      if (stall_pc && stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core.
// Merges per-stage stall requests into the stall vector, sequences
// exception/ERET flushes with a redirect PC, and blocks further exceptions
// for RECOVER_CYCLES cycles after each flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stallreq_if/id/ex/mem    per-stage stall requests
//   excp_valid, excp_type    exception committed in MEM, code (5'h0E = ERET)
//   cp0_epc                  return address used for ERET
//   stall                    {wb,mem,ex,id,if,pc}, 1 = hold
//   flush, new_pc            flush pulse and redirect target
//   wdog_timeout, stall_err  watchdog pulse and sticky error
//   stall_cycles             saturating count of pc-stall cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [4:0]  excp_type,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_timeout,
  output logic        stall_err,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0] RecoverLoad = 4'(RECOVER_CYCLES);

  ctrl_state_e state_q;
  logic [3:0]  recover_cnt_q;
  logic        take;

  always_comb begin
    take = !rst && excp_valid && (state_q == StRun);
    if (rst || take) begin
      stall = StallNone;  // a flush discards whatever was stalling
    end else begin
      stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    end
    flush = take;
    if (take) begin
      new_pc = (excp_type == ExcEret) ? cp0_epc : EXC_VECTOR;
    end else begin
      new_pc = ZeroWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      recover_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (take) begin
            state_q       <= StRecover;
            recover_cnt_q <= RecoverLoad;
          end
        end
        StRecover: begin
          if (recover_cnt_q == 4'd1) begin
            state_q       <= StRun;
            recover_cnt_q <= '0;
          end else begin
            recover_cnt_q <= recover_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q       <= StRun;
          recover_cnt_q <= '0;
        end
      endcase
    end
  end

  ctrl_wdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .stall_pc    (stall[0]),
    .flush       (flush),
    .wdog_timeout(wdog_timeout),
    .stall_err   (stall_err),
    .stall_cycles(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam logic [31:0] ExcVec = 32'h0000_0020;
  localparam int          Recov  = 2;
  localparam int          WLim   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b1, stallreq_id = 1'b1, stallreq_ex = 1'b1, stallreq_mem = 1'b1;
  logic        excp_valid = 1'b1;
  logic [4:0]  excp_type = 5'h04;
  logic [31:0] cp0_epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_timeout;
  logic        stall_err;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR    (ExcVec),
    .RECOVER_CYCLES(Recov),
    .WDOG_LIMIT    (WLim)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excp_valid  (excp_valid),
    .excp_type   (excp_type),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .wdog_timeout(wdog_timeout),
    .stall_err   (stall_err),
    .stall_cycles(stall_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: cycles since the last taken flush, length of the current stall run,
  // sticky error and total stall count since reset.
  int          since_flush = 1000;
  longint      run = 0;
  logic        m_err = 1'b0;
  longint      m_cycles = 0;
  bit          m_valid = 0;
  logic        e_take = 1'b0;
  logic [5:0]  e_stall = '0;
  logic        e_wd = 1'b0;
  logic [31:0] e_pc = '0;

  always @(negedge clk) begin
    int lvl;
    lvl = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    e_take  = !rst && excp_valid && (since_flush > Recov);
    e_stall = (rst || e_take) ? 6'd0 : 6'((1 << lvl) - 1);
    e_pc    = e_take ? ((excp_type == 5'h0E) ? cp0_epc : ExcVec) : 32'h0;
    e_wd    = !rst && e_stall[0] && (((run + 1) % WLim) == 0);
    check("cyc_stall", {26'd0, stall}, {26'd0, e_stall});
    check("cyc_flush", {31'd0, flush}, {31'd0, e_take});
    check("cyc_new_pc", new_pc, e_pc);
    check("cyc_wdog", {31'd0, wdog_timeout}, {31'd0, e_wd});
    if (m_valid) begin
      check("cyc_stall_err", {31'd0, stall_err}, {31'd0, m_err});
      check("cyc_stall_cycles", stall_cycles, 32'(m_cycles));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      since_flush = 1000;
      run         = 0;
      m_err       = 1'b0;
      m_cycles    = 0;
      m_valid     = 1;
    end else begin
      if (e_take) since_flush = 1;
      else if (since_flush < 1000) since_flush = since_flush + 1;
      if (e_stall[0]) begin
        run = run + 1;
        if (m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
      end else begin
        run = 0;
      end
      if (e_wd) m_err = 1'b1;
    end
  end

  // One cycle: change inputs just after the edge, return at the following negedge.
  // req bits are {mem, ex, id, if}.
  task automatic set_in(input logic r, input logic [3:0] req, input logic ev,
                        input logic [4:0] et, input logic [31:0] epc);
    @(posedge clk);
    #1;
    rst          = r;
    stallreq_mem = req[3];
    stallreq_ex  = req[2];
    stallreq_id  = req[1];
    stallreq_if  = req[0];
    excp_valid   = ev;
    excp_type    = et;
    cp0_epc      = epc;
    @(negedge clk);
  endtask

  task automatic idle();
    set_in(1'b0, 4'b0000, 1'b0, 5'h00, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    // Reset holds all outputs low despite active requests.
    @(negedge clk);
    check("rst_stall", {26'd0, stall}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_new_pc", new_pc, 32'd0);
    check("rst_wdog", {31'd0, wdog_timeout}, 32'd0);
    set_in(1'b1, 4'b1111, 1'b1, 5'h04, 32'h0);
    check("rst_stall_err", {31'd0, stall_err}, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    idle();
    check("idle_stall", {26'd0, stall}, 32'd0);

    // Priority encoding.
    set_in(1'b0, 4'b0101, 1'b0, 5'h00, 32'h0);
    check("prio_if_ex", {26'd0, stall}, 32'b001111);
    set_in(1'b0, 4'b1101, 1'b0, 5'h00, 32'h0);
    check("prio_mem", {26'd0, stall}, 32'b011111);
    idle();
    check("prio_none", {26'd0, stall}, 32'd0);
    check("count_after_2", stall_cycles, 32'd2);
    set_in(1'b0, 4'b0010, 1'b0, 5'h00, 32'h0);
    check("prio_id", {26'd0, stall}, 32'b000111);
    set_in(1'b0, 4'b0001, 1'b0, 5'h00, 32'h0);
    check("prio_if", {26'd0, stall}, 32'b000011);
    idle();
    check("count_after_4", stall_cycles, 32'd4);

    // Exception and ERET redirects.
    set_in(1'b0, 4'b0000, 1'b1, 5'h04, 32'hDEAD_BEEF);
    check("exc_flush", {31'd0, flush}, 32'd1);
    check("exc_new_pc", new_pc, 32'h0000_0020);
    check("exc_stall", {26'd0, stall}, 32'd0);
    idle();
    idle();
    set_in(1'b0, 4'b0000, 1'b1, 5'h0E, 32'h0040_0100);
    check("eret_flush", {31'd0, flush}, 32'd1);
    check("eret_new_pc", new_pc, 32'h0040_0100);
    idle();
    idle();

    // Recovery window with excp_valid held four cycles.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 4'b0000, 1'b1, 5'h04, 32'h0);
      check($sformatf("window_%0d", i), {31'd0, flush}, (i == 0 || i == 3) ? 32'd1 : 32'd0);
    end
    idle();
    idle();

    // Flush beats a simultaneous stall and the stall is not counted.
    set_in(1'b0, 4'b1000, 1'b1, 5'h04, 32'h0);
    check("fvs_flush", {31'd0, flush}, 32'd1);
    check("fvs_stall", {26'd0, stall}, 32'd0);
    idle();
    check("fvs_count", stall_cycles, 32'd4);
    idle();

    // Watchdog expires on the 8th consecutive stall cycle.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 4'b0010, 1'b0, 5'h00, 32'h0);
      check($sformatf("wdog_%0d", i), {31'd0, wdog_timeout}, (i == 7) ? 32'd1 : 32'd0);
    end
    idle();
    check("wdog_err", {31'd0, stall_err}, 32'd1);
    check("wdog_count", stall_cycles, 32'd12);
    idle();
    check("wdog_err_sticky", {31'd0, stall_err}, 32'd1);

    // Reset clears the sticky error and the counter.
    set_in(1'b1, 4'b0000, 1'b0, 5'h00, 32'h0);
    idle();
    check("post_rst_err", {31'd0, stall_err}, 32'd0);
    check("post_rst_count", stall_cycles, 32'd0);

    // Reset in the middle of recovery reopens exceptions immediately.
    set_in(1'b0, 4'b0000, 1'b1, 5'h04, 32'h0);
    check("mid_rec_flush0", {31'd0, flush}, 32'd1);
    set_in(1'b1, 4'b0000, 1'b1, 5'h04, 32'h0);
    check("mid_rec_rst_flush", {31'd0, flush}, 32'd0);
    set_in(1'b0, 4'b0000, 1'b1, 5'h0E, 32'h0040_0200);
    check("mid_rec_flush1", {31'd0, flush}, 32'd1);
    check("mid_rec_pc", new_pc, 32'h0040_0200);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
